// File: rtl/riscv_mem_pkg.sv
// Shared types and sizing helpers for the riscv_main_memory line responder.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

    localparam int unsigned DEF_LINE_W = 32'd128;
    localparam int unsigned DEF_DEPTH  = 32'd1024;
    localparam int unsigned DEF_ADDR_W = 32'd64;

    // Byte-offset width of one cache line.
    function automatic int unsigned line_off(input int unsigned line_w);
        return $clog2(line_w / 32'd8);
    endfunction

endpackage

// File: rtl/riscv_main_memory_if.sv
// Refill/writeback bus between the data cache (master) and main memory (slave).
// With RISCV_MEM_ADDR_CHECK_EN defined the slave also drives o_riscv_mem_err.
interface riscv_main_memory_if
    import riscv_mem_pkg::*;
#(
    parameter int unsigned LINE_W = DEF_LINE_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);

    logic              i_riscv_mem_wren;
    logic              i_riscv_mem_rden;
    logic [ADDR_W-1:0] i_riscv_mem_addr;
    logic [LINE_W-1:0] i_riscv_mem_wdata;
    logic [LINE_W-1:0] o_riscv_mem_rdata;
    logic              o_riscv_mem_done;
    logic              o_riscv_mem_busy;

`ifdef RISCV_MEM_ADDR_CHECK_EN
    logic              o_riscv_mem_err;

    modport master (
        output i_riscv_mem_wren, i_riscv_mem_rden, i_riscv_mem_addr, i_riscv_mem_wdata,
        input  o_riscv_mem_rdata, o_riscv_mem_done, o_riscv_mem_busy, o_riscv_mem_err
    );

    modport slave (
        input  i_riscv_mem_wren, i_riscv_mem_rden, i_riscv_mem_addr, i_riscv_mem_wdata,
        output o_riscv_mem_rdata, o_riscv_mem_done, o_riscv_mem_busy, o_riscv_mem_err
    );
`else
    modport master (
        output i_riscv_mem_wren, i_riscv_mem_rden, i_riscv_mem_addr, i_riscv_mem_wdata,
        input  o_riscv_mem_rdata, o_riscv_mem_done, o_riscv_mem_busy
    );

    modport slave (
        input  i_riscv_mem_wren, i_riscv_mem_rden, i_riscv_mem_addr, i_riscv_mem_wdata,
        output o_riscv_mem_rdata, o_riscv_mem_done, o_riscv_mem_busy
    );
`endif

endinterface

// File: rtl/riscv_mem_array.sv
// Synchronous single-port line RAM; contents are never reset.
module riscv_mem_array #(
    parameter int unsigned LINE_W = 32'd128,
    parameter int unsigned DEPTH  = 32'd1024,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem_r [DEPTH];

    // Write-then-registered-read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[idx] <= wdata;
        end
        rdata <= mem_r[idx];
    end

endmodule

// File: rtl/riscv_main_memory.sv
// Fixed-latency whole-line backing memory for the data cache refill/writeback path.
// RISCV_MEM_ADDR_CHECK_EN adds o_riscv_mem_err for addresses beyond the stored range.
module riscv_main_memory
    import riscv_mem_pkg::*;
#(
    parameter int unsigned LINE_W  = DEF_LINE_W,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned LATENCY = 32'd4
) (
    input  logic               i_riscv_mem_clk,
    input  logic               i_riscv_mem_rst,
    riscv_main_memory_if.slave mem
);

    localparam int unsigned OFF   = line_off(LINE_W);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (LATENCY > 32'd1) ? $clog2(LATENCY) : 32'd1;

    mem_state_t        state_r, state_n_s;
    logic [CNT_W-1:0]  cnt_r, cnt_n_s;
    mem_op_t           op_r;
    logic [IDX_W-1:0]  idx_r, in_idx_s, ram_idx_s;
    logic [LINE_W-1:0] wdata_r, ram_q_s, hold_r, rdata_s;
    logic              flag_r, flag_n_s, addr_hi_s;
    logic              req_s, accept_s;
    logic              done_r, busy_r, done_s, busy_s;
    logic              ram_we_s, rdata_live_s;
    logic              unused_addr_s;

    assign req_s         = mem.i_riscv_mem_wren | mem.i_riscv_mem_rden;
    assign in_idx_s      = mem.i_riscv_mem_addr[OFF +: IDX_W];
    assign unused_addr_s = ^mem.i_riscv_mem_addr;

`ifdef RISCV_MEM_ADDR_CHECK_EN
    assign addr_hi_s = |(mem.i_riscv_mem_addr >> (OFF + IDX_W));
`else
    assign addr_hi_s = 1'b0;
`endif

    riscv_mem_array #(
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (i_riscv_mem_clk),
        .we    (ram_we_s),
        .idx   (ram_idx_s),
        .wdata (wdata_r),
        .rdata (ram_q_s)
    );

    // Next-state and latency counter.
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        accept_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    accept_s = 1'b1;
                    cnt_n_s  = CNT_W'(LATENCY - 32'd1);
                    if (LATENCY == 32'd1) begin
                        state_n_s = DONE;
                    end else begin
                        state_n_s = WAIT;
                    end
                end else begin
                    state_n_s = IDLE;
                end
            end
            WAIT: begin
                cnt_n_s = cnt_r - CNT_W'(1'b1);
                if (cnt_r == CNT_W'(1'b1)) begin
                    state_n_s = DONE;
                end else begin
                    state_n_s = WAIT;
                end
            end
            DONE: begin
                state_n_s = IDLE;
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // RAM steering and output values; the RAM is addressed from the bus while idle
    // so a single-cycle read still has its line ready in the DONE cycle.
    always_comb begin
        flag_n_s     = accept_s ? addr_hi_s : flag_r;
        done_s       = (state_n_s == DONE);
        busy_s       = (state_n_s != IDLE);
        ram_we_s     = (state_r == DONE) && (op_r == OP_WRITE) && !flag_r && !i_riscv_mem_rst;
        ram_idx_s    = (state_r == IDLE) ? in_idx_s : idx_r;
        rdata_live_s = (state_r == DONE) && (op_r == OP_READ);
        if (!rdata_live_s) begin
            rdata_s = hold_r;
        end else if (flag_r) begin
            rdata_s = {LINE_W{1'b0}};
        end else begin
            rdata_s = ram_q_s;
        end
    end

    // State, request latches and registered status outputs.
    always_ff @(posedge i_riscv_mem_clk) begin
        if (i_riscv_mem_rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= OP_READ;
            idx_r   <= {IDX_W{1'b0}};
            wdata_r <= {LINE_W{1'b0}};
            flag_r  <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            hold_r  <= {LINE_W{1'b0}};
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
            flag_r  <= flag_n_s;
            done_r  <= done_s;
            busy_r  <= busy_s;
            if (accept_s) begin
                op_r    <= mem.i_riscv_mem_wren ? OP_WRITE : OP_READ;
                idx_r   <= in_idx_s;
                wdata_r <= mem.i_riscv_mem_wdata;
            end
            if (rdata_live_s) begin
                hold_r <= rdata_s;
            end
        end
    end

    assign mem.o_riscv_mem_done  = done_r;
    assign mem.o_riscv_mem_busy  = busy_r;
    assign mem.o_riscv_mem_rdata = rdata_s;

`ifdef RISCV_MEM_ADDR_CHECK_EN
    logic err_r;

    // Error flag is only ever raised alongside done.
    always_ff @(posedge i_riscv_mem_clk) begin
        if (i_riscv_mem_rst) begin
            err_r <= 1'b0;
        end else begin
            err_r <= done_s & flag_n_s;
        end
    end

    assign mem.o_riscv_mem_err = err_r;
`endif

endmodule

// File: doc/riscv_main_memory.md
Name: riscv_main_memory

Overview:
- Backing-memory responder at the far end of the data cache's refill/writeback interface.
- Accepts whole-line read (refill) and write (writeback) requests from riscv_data_cache.
- Models a fixed multi-cycle access latency and signals completion with a one-cycle done pulse.
- Instantiated in the top level beside the core and data cache; it is the memory the cache stalls on.

Parameters:
- LINE_W, 128, cache line width in bits; a multiple of 8.
- DEPTH, 1024, number of lines stored; a power of 2.
- ADDR_W, 64, byte-address width from the cache.
- LATENCY, 4, cycles from request acceptance to done; 1 or more.

Ports:
- i_riscv_mem_clk  in  1  clock; all logic rises on the posedge.
- i_riscv_mem_rst  in  1  reset; synchronous, active-high.
- i_riscv_mem_wren  in  1  writeback request; held by the cache until done.
- i_riscv_mem_rden  in  1  refill request; held by the cache until done.
- i_riscv_mem_addr  in  ADDR_W  byte address; the line offset bits are ignored.
- i_riscv_mem_wdata  in  LINE_W  line to write.
- o_riscv_mem_rdata  out  LINE_W  refill line; valid in the done cycle.
- o_riscv_mem_done  out  1  one-cycle completion pulse.
- o_riscv_mem_busy  out  1  high while a request is in flight.

Behaviour:
- Reset: synchronous, active-high, sampled at posedge.
  - State goes to IDLE; counter=0; o_riscv_mem_done=0; o_riscv_mem_busy=0; o_riscv_mem_rdata=0.
  - Storage array is not cleared.
- Line index = addr[OFF+IDX_W-1:OFF], where OFF=log2(LINE_W/8) and IDX_W=log2(DEPTH). Upper address bits wrap (are ignored).
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If wren or rden is high, latch op, index and wdata; set busy=1; counter=LATENCY-1.
  - Go to DONE if LATENCY==1, else go to WAIT.
- WAIT: decrement counter each cycle; at counter==1, go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy stays 1 during this cycle.
  - Write op: the latched line is committed to the array in this cycle.
  - Read op: rdata is loaded from the array and held until the next read completes.
  - Then go to IDLE with busy=0.
- Latency: a request sampled at cycle N produces done at cycle N+LATENCY.
- Inputs are sampled only at acceptance; changes during WAIT/DONE are ignored.
- Request still high in the DONE cycle: it is not re-accepted that cycle. If still high in the following IDLE cycle, it is accepted as a new request (one-cycle turnaround). The cache must drop its request on done.
- wren and rden both high: the write takes priority, no read occurs, rdata is unchanged, and done still pulses once.
- Reset mid-operation: the transaction is aborted, no array write occurs, and done is not pulsed.
- A read of a never-written line returns X in simulation; the bench preloads lines.

Optional Feature:
- Macro: RISCV_MEM_ADDR_CHECK_EN.
- When defined:
  - Adds port o_riscv_mem_err (out, 1).
  - At acceptance, if any address bit above OFF+IDX_W is set, the request is flagged.
  - A flagged request still completes with normal latency; err=1 together with done.
  - A flagged write does not write the array; a flagged read drives rdata=0.
  - err resets to 0 and is 0 whenever done is 0.
- When undefined: no err port; upper address bits wrap silently.

Decomposition:
- Package riscv_mem_pkg:
  - enum mem_state_t {IDLE, WAIT, DONE}
  - enum mem_op_t {OP_READ, OP_WRITE}
  - constants for default LINE_W and DEPTH
  - function computing OFF from LINE_W
- Sub-module riscv_mem_array: synchronous single-port line RAM (clk, we, idx, wdata, rdata) with no reset. The top holds the FSM, latency counter and request latches.

Test Plan:
- Reset, then write line 0xDEADBEEF_CAFEF00D_01234567_89ABCDEF to addr 0x40 (idx 4); later read addr 0x40:
  - done pulses exactly 4 cycles after each acceptance.
  - The read returns the same 128-bit value; busy is high for 4 cycles each time.
- LATENCY=1 build: read request at cycle 10 -> done and valid rdata at cycle 11; back-to-back held request -> next done at cycle 13.
- wren=rden=1 at addr 0x80 with wdata=0x5 -> one done pulse, line 8 becomes 0x5, rdata keeps its previous value.
- Assert rst at cycle 2 of a write to addr 0x100 -> no done pulse; a subsequent read of 0x100 returns the preloaded value, not the aborted write data.
- Change addr and wdata during WAIT -> the originally latched addr and data are used.
- RISCV_MEM_ADDR_CHECK_EN, DEPTH=1024: read at addr 0x1_0000_0040 -> done with err=1 and rdata=0. Without the macro, the same address returns line 4.
